// File: rtl/phase_to_sine.sv
// -----------------------------------------------------------------------------
// phase_to_sine
//   Turns a 10-bit phase word (full cycle = 1024) into a signed sine sample.
//   It uses a 64-entry quarter-wave ROM with quadrant mirroring and negation.
//   The pipeline has three registered stages, and each stage carries a valid
//   tag, so latency is exactly 3 cycles and throughput is one sample per cycle.
//   A rising zero crossing of the output waveform is flagged for downstream
//   frame alignment.
//
//   Optional feature macro: PHASE_TO_SINE_COS_OUT_EN
//     When defined, a cosine output is added. It is computed from
//     (phase + 256) mod 1024 through the same ROM, and it is cycle-aligned with
//     sine and qualified by sine_valid.
//
// Ports
//   clock        system clock
//   reset        synchronous, active-high; clears every pipeline register
//   phase        unsigned phase word; phase[1:0] is ignored
//   phase_valid  phase is sampled this cycle
//   sine         signed sample, range -511..+511, holds value during bubbles
//   sine_valid   sine carries a new sample this cycle
//   zero_cross   new sample >= 0 and previous valid sample < 0
//   cosine       signed cosine sample (only with PHASE_TO_SINE_COS_OUT_EN)
// -----------------------------------------------------------------------------
module phase_to_sine #(
   parameter int AMP_W     = 10,
   parameter int TBL_DEPTH = 64
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [9:0]              phase,
   input  logic                    phase_valid,
   output logic signed [AMP_W-1:0] sine,
   output logic                    sine_valid,
   output logic                    zero_cross
`ifdef PHASE_TO_SINE_COS_OUT_EN
   ,
   output logic signed [AMP_W-1:0] cosine
`endif
);

   localparam int IDX_W = $clog2(TBL_DEPTH);

   // round(511 * sin((pi/2) * (k + 0.5) / 64)), k = 0..63
   function automatic logic [8:0] qw_rom(input logic [IDX_W-1:0] idx);
      logic [8:0] r;
      case (idx)
         6'd0:  r = 9'd6;   6'd1:  r = 9'd19;  6'd2:  r = 9'd31;  6'd3:  r = 9'd44;
         6'd4:  r = 9'd56;  6'd5:  r = 9'd69;  6'd6:  r = 9'd81;  6'd7:  r = 9'd94;
         6'd8:  r = 9'd106; 6'd9:  r = 9'd118; 6'd10: r = 9'd130; 6'd11: r = 9'd142;
         6'd12: r = 9'd154; 6'd13: r = 9'd166; 6'd14: r = 9'd178; 6'd15: r = 9'd190;
         6'd16: r = 9'd201; 6'd17: r = 9'd213; 6'd18: r = 9'd224; 6'd19: r = 9'd235;
         6'd20: r = 9'd246; 6'd21: r = 9'd257; 6'd22: r = 9'd268; 6'd23: r = 9'd279;
         6'd24: r = 9'd289; 6'd25: r = 9'd299; 6'd26: r = 9'd309; 6'd27: r = 9'd319;
         6'd28: r = 9'd329; 6'd29: r = 9'd338; 6'd30: r = 9'd348; 6'd31: r = 9'd357;
         6'd32: r = 9'd366; 6'd33: r = 9'd374; 6'd34: r = 9'd383; 6'd35: r = 9'd391;
         6'd36: r = 9'd399; 6'd37: r = 9'd407; 6'd38: r = 9'd414; 6'd39: r = 9'd421;
         6'd40: r = 9'd428; 6'd41: r = 9'd435; 6'd42: r = 9'd441; 6'd43: r = 9'd448;
         6'd44: r = 9'd454; 6'd45: r = 9'd459; 6'd46: r = 9'd465; 6'd47: r = 9'd470;
         6'd48: r = 9'd474; 6'd49: r = 9'd479; 6'd50: r = 9'd483; 6'd51: r = 9'd487;
         6'd52: r = 9'd491; 6'd53: r = 9'd494; 6'd54: r = 9'd497; 6'd55: r = 9'd500;
         6'd56: r = 9'd502; 6'd57: r = 9'd505; 6'd58: r = 9'd506; 6'd59: r = 9'd508;
         6'd60: r = 9'd509; 6'd61: r = 9'd510; 6'd62: r = 9'd511; 6'd63: r = 9'd511;
         default: r = 9'd0;
      endcase
      return r;
   endfunction

   // Odd quadrants run the table backwards. For a 6-bit index, 63 - k equals ~k.
   function automatic logic [IDX_W-1:0] mirror_idx(input logic [9:0] p);
      return p[8] ? ~p[7:2] : p[7:2];
   endfunction

   function automatic logic signed [AMP_W-1:0] apply_sign(input logic [8:0] mag,
                                                          input logic       neg);
      logic signed [AMP_W-1:0] ext;
      ext = $signed({{(AMP_W-9){1'b0}}, mag});
      return neg ? -ext : ext;
   endfunction

   // The two LSBs of phase are below table resolution (no interpolation).
   logic unused_lsb;
   assign unused_lsb = ^phase[1:0];

   // Stage 1: index / sign
   logic [IDX_W-1:0] m1;
   logic             n1, v1;
   // Stage 2: magnitude
   logic [8:0]       mag2;
   logic             n2, v2;
   // Sign of the last valid output; 1 = negative
   logic             prev_neg;

`ifdef PHASE_TO_SINE_COS_OUT_EN
   logic [9:0]       cphase;
   logic [IDX_W-1:0] cm1;
   logic             cn1;
   logic [8:0]       cmag2;
   logic             cn2;

   assign cphase = phase + 10'd256;   // 10-bit wrap gives mod 1024
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         m1         <= '0;
         n1         <= 1'b0;
         v1         <= 1'b0;
         mag2       <= '0;
         n2         <= 1'b0;
         v2         <= 1'b0;
         sine       <= '0;
         sine_valid <= 1'b0;
         zero_cross <= 1'b0;
         prev_neg   <= 1'b0;
`ifdef PHASE_TO_SINE_COS_OUT_EN
         cm1        <= '0;
         cn1        <= 1'b0;
         cmag2      <= '0;
         cn2        <= 1'b0;
         cosine     <= '0;
`endif
      end else begin
         // stage 1
         m1   <= mirror_idx(phase);
         n1   <= phase[9];
         v1   <= phase_valid;
         // stage 2
         mag2 <= qw_rom(m1);
         n2   <= n1;
         v2   <= v1;
         // stage 3
         sine_valid <= v2;
         // The table has no zero entry, so the sign of the sample is exactly n2.
         zero_cross <= v2 & ~n2 & prev_neg;
         if (v2) begin
            sine     <= apply_sign(mag2, n2);
            prev_neg <= n2;
         end
`ifdef PHASE_TO_SINE_COS_OUT_EN
         cm1   <= mirror_idx(cphase);
         cn1   <= cphase[9];
         cmag2 <= qw_rom(cm1);
         cn2   <= cn1;
         if (v2)
            cosine <= apply_sign(cmag2, cn2);
`endif
      end
   end

endmodule

// File: doc/phase_to_sine.md
Name: phase_to_sine

Overview:
- Consumer end of the 10-bit phase interface driven by the phase accumulator. Converts each phase word into a signed sine sample for the equalizer tone path.
- Uses a 64-entry quarter-wave table with quadrant mirroring and negation.
- Three-stage valid-tagged pipeline.
- Flags rising zero crossings of the generated waveform for downstream frame alignment.

Parameters:
- AMP_W, 10, output sample width (signed, two's complement). The table is specified for 10; other values are not supported.
- TBL_DEPTH, 64, quarter-wave table entries. Fixed: index = phase[7:2].

Ports:
- clock  input  1  system clock (1 MHz domain)
- reset  input  1  synchronous, active-high reset
- phase  input  10  phase word, unsigned, full cycle = 1024
- phase_valid  input  1  phase is sampled this cycle
- sine  output  10  signed sine sample
- sine_valid  output  1  sine holds a new sample this cycle
- zero_cross  output  1  rising zero crossing, qualified by sine_valid
- cosine  output  10  signed cosine sample; only present with COS_OUT_EN

Behaviour:
- Reset is sampled on the clock edge only. On reset, every pipeline register clears:
  - sine = 0, sine_valid = 0, zero_cross = 0, cosine = 0.
  - Previous-sign register = 0 (treated as non-negative).
- Reset asserted mid-stream discards all in-flight samples. The first valid output after reset release appears 3 cycles after the first accepted phase_valid.
- Decomposition: q = phase[9:8], k = phase[7:2]. phase[1:0] is ignored; no interpolation.
- Table: T[k] = round(511 * sin((pi/2) * (k + 0.5) / 64)), k = 0..63, unsigned 9-bit.
  - T[0] = 6, T[32] = 366, T[63] = 511.
  - Implemented as a constant case ROM.
- Stage 1 (register):
  - Mirrored index m = k when q[0] = 0, else 63 - k.
  - Negate flag n = q[1].
  - v1 = phase_valid.
- Stage 2 (register): mag = T[m], n2 = n, v2 = v1.
- Stage 3 (register):
  - sine = n2 ? -mag : +mag, sign-extended to 10 bits. Range is -511..+511; -512 never occurs.
  - sine_valid = v2.
- Latency: exactly 3 cycles from phase_valid to sine_valid.
- Throughput: one sample per cycle. No backpressure; the consumer must accept every sine_valid.
- Bubbles: when phase_valid = 0, bubbles propagate. sine holds its last value while sine_valid = 0.
- Zero crossing:
  - zero_cross = 1 in the same cycle as sine_valid when the new sample is non-negative and the previous valid sample was negative.
  - Previous sign updates only on valid samples. Bubbles do not break crossing detection.
- Wrap-around: phase 1023 -> 0 is continuous. The sequence -6 then +6 raises zero_cross.
- Monotonic accumulator values ≥ 1024 cannot occur (10-bit port). No special handling is required.

Optional Feature:
- Macro: PHASE_TO_SINE_COS_OUT_EN.
- Defined:
  - Adds the cosine port and a second lookup path driven by (phase + 256) mod 1024, computed in stage 1.
  - Uses the same table, mirroring and negation.
  - cosine is aligned with sine and qualified by the same sine_valid.
- Undefined:
  - The cosine port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: assert reset for 2 cycles, then phase_valid = 0 -> sine = 0, sine_valid = 0, zero_cross = 0 throughout.
- Quadrant points: phase 0, 128, 256, 512, 768 on consecutive cycles with phase_valid = 1 -> starting 3 cycles later, sine = 6, 366, 511, -6, -511, with sine_valid high for 5 cycles.
- Accumulator stream: phase stepping by 3 from 0 for 700 cycles -> every output equals the model, and zero_cross pulses exactly once per wrap (1023 -> 0 region) with value +6.
- Bubbles and reset: alternate phase_valid 1/0 with phase 1000, 1020, 4, 8 -> zero_cross fires on the sample of phase 4 despite the gaps. Assert reset while 2 samples are in flight -> neither emerges.
- Cosine (COS_OUT_EN defined): phase 0 -> cosine = 511. Phase 256 -> cosine = -6. Phase 768 -> cosine = 6. Both outputs are cycle-aligned with sine.
